// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, EX/MEM state encoding and opcode classing.
package cpu_pkg;

  localparam logic [4:0] OP_LDR = 5'd8;
  localparam logic [4:0] OP_STR = 5'd9;
  localparam logic [4:0] OP_B   = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ABORT    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_LDR:  return CLS_LOAD;
      OP_STR:  return CLS_STORE;
      OP_B:    return CLS_BRANCH;
      default: return CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts MEM_WAIT cycles without an ack; expired marks the last permitted wait cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (enable)
      r_count <= r_count + CW'(1);
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: retires ALU results in one cycle and sequences one
// data-memory access at a time, aborting with a sticky error on timeout.
//
// state       | meaning
// ST_IDLE     | accepting instructions; ALU results retire from here
// ST_MEM_WAIT | load/store request outstanding, waiting for mem_ack
// ST_ABORT    | one-cycle recovery after a timed-out request
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_opcode,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_store_data,
  input  logic        flush,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  state_t      r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [4:0]  r_rd;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_mem_err;

  op_class_t   w_class;
  logic        w_capture;
  logic        w_ctr_clear;
  logic        w_ctr_en;
  logic        w_expired;

  assign w_class     = op_class(in_opcode);
  // A flush on a would-be capture edge blocks the capture outright.
  assign w_capture   = (r_state == ST_IDLE) && in_valid && !flush;
  assign w_ctr_clear = w_capture && ((w_class == CLS_LOAD) || (w_class == CLS_STORE));
  assign w_ctr_en    = (r_state == ST_MEM_WAIT) && !mem_ack && !w_expired;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_ctr_clear),
    .enable  (w_ctr_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd        <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            case (w_class)
              CLS_ALU: begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= in_rd;
                r_wb_data  <= in_result;
              end
              CLS_LOAD, CLS_STORE: begin
                r_state     <= ST_MEM_WAIT;
                r_mem_req   <= 1'b1;
                r_mem_we    <= (w_class == CLS_STORE);
                r_mem_addr  <= in_result;
                r_mem_wdata <= in_store_data;
                r_rd        <= in_rd;
              end
              default: ;
            endcase
          end
        end
        ST_MEM_WAIT: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= mem_rdata;
            end
          end else if (w_expired) begin
            r_state   <= ST_ABORT;
            r_mem_req <= 1'b0;
            r_mem_err <= 1'b1;
          end
        end
        ST_ABORT: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = (r_state == ST_MEM_WAIT) || (r_state == ST_ABORT);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign mem_err   = r_mem_err;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  ALU stage presents an instruction.
- in_opcode  in  5  opcode forwarded by the ALU.
- in_result  in  32  AluResult: ALU value, or effective address for load/store.
- in_rd  in  5  destination register index.
- in_store_data  in  32  Rt value to store.
- flush  in  1  discard the held non-memory instruction.
- stall  out  1  upstream holds its outputs.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completed the request (one cycle).
- mem_rdata  in  32  load data, valid with mem_ack.
- wb_valid  out  1  writeback strobe, one cycle.
- wb_rd  out  5  writeback register index.
- wb_data  out  32  writeback value.
- mem_err  out  1  sticky timeout flag.

Function
REQ-004 The block SHALL be a three-state FSM: IDLE, MEM_WAIT, ABORT.
REQ-005 In IDLE, in_valid SHALL be captured on the clock edge; in_valid is ignored while stall=1.
REQ-006 The opcode class SHALL be decided as follows:
- OP_LDR = 5'd8 is a load.
- OP_STR = 5'd9 is a store.
- OP_B = 5'd10 is a branch with no writeback.
- All other opcodes are ALU writeback ops.
REQ-007 An ALU op SHALL have 1-cycle latency: on the cycle after capture, wb_valid=1, wb_rd=in_rd and wb_data=in_result; the FSM stays in IDLE.
REQ-008 A branch SHALL produce no wb_valid and no memory traffic.
REQ-009 A load or store SHALL move the FSM to MEM_WAIT.
REQ-010 From the cycle after capture, the block SHALL drive mem_req=1, mem_addr=in_result, mem_we=(opcode==OP_STR) and mem_wdata=in_store_data, all held stable until mem_ack is sampled.
REQ-011 stall SHALL equal (state==MEM_WAIT || state==ABORT), decoded from registered state only.
REQ-012 When mem_ack=1 in MEM_WAIT, the block SHALL behave as follows:
- mem_req drops the next cycle.
- FSM returns to IDLE.
- For a load, the next cycle has wb_valid=1, wb_rd=held rd and wb_data=mem_rdata.
- For a store, there is no wb_valid.
REQ-013 A counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack.
REQ-014 When the counter reaches TIMEOUT-1 without ack, the FSM SHALL go to ABORT, set mem_err=1 (sticky), drop mem_req and suppress wb_valid.
REQ-015 ABORT SHALL last exactly one cycle and then return to IDLE.
REQ-016 If mem_ack coincides with the timeout cycle, the ack SHALL win: normal completion and no mem_err.
REQ-017 mem_ack while in IDLE or ABORT SHALL be ignored.
REQ-018 If flush=1 on the edge where an ALU op would produce wb_valid, the block SHALL suppress that wb_valid and SHALL NOT capture a new instruction that cycle.
REQ-019 flush SHALL be ignored in MEM_WAIT, because a memory operation is committed once requested.
REQ-020 wb_valid SHALL never stay high two consecutive cycles for the same instruction; back-to-back ALU ops give wb_valid on consecutive cycles.

Reset
REQ-021 On rst=1 at a clock edge, the block SHALL:
- set the state to IDLE;
- set stall, mem_req, mem_we, wb_valid and mem_err to 0;
- set mem_addr, mem_wdata, wb_rd, wb_data and the counter to 0.
REQ-022 rst SHALL take priority over all inputs; rst during MEM_WAIT abandons the request (mem_req=0 next cycle) with no writeback.

Structure
REQ-023 Opcode constants (OP_LDR, OP_STR, OP_B) and the state enum SHALL live in a shared package, cpu_pkg, which the ALU also imports.
REQ-024 The timeout counter SHALL be a sub-module, mem_timeout_ctr, with ports clk, rst, clear, enable and expired, parameterised by TIMEOUT.

Verification
REQ-025 The bench SHALL cover these scenarios:
- ALU op: opcode 2, result 0x0000_0007, rd 3 -> next cycle wb_valid=1, wb_rd=3, wb_data=7; stall stays 0.
- Load: opcode 8, result 0x40; ack after 3 cycles with rdata 0xDEAD_BEEF -> mem_req high 3 cycles, addr 0x40, we=0, stall high 3 cycles; next cycle wb_data=0xDEAD_BEEF.
- Store: opcode 9, addr 0x10, store data 0x55 -> mem_we=1, mem_wdata=0x55; no wb_valid after ack.
- Timeout: load, no ack, TIMEOUT=16 -> ABORT after 16 MEM_WAIT cycles, mem_err=1 sticky, no wb_valid; ack on cycle 16 instead -> normal completion, mem_err=0.
- Flush/branch: ALU op with flush on the writeback edge -> no wb_valid; opcode 10 -> no wb_valid and no mem_req.
- Reset mid-MEM_WAIT -> mem_req=0, stall=0, mem_err=0 next cycle; a subsequent ALU op completes normally.
